// File: rtl/even_parity_pkg.sv
// Shared definitions for the even-parity generator/checker pair.
package even_parity_pkg;

    localparam int DATA_W       = 8;
    localparam int CNT_W        = 16;
    localparam int PARITY_MAX_W = 64;

    // Zero-extending the data to a fixed width leaves its XOR reduction unchanged.
    function automatic logic even_parity(input logic [PARITY_MAX_W-1:0] data);
        return ^data;
    endfunction

endpackage

// File: rtl/parity_stat_counter.sv
// Statistics counter with synchronous clear; SAT selects saturate (1) or wrap (0).
module parity_stat_counter #(
    parameter int CNT_W = 16,
    parameter bit SAT   = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] cnt
);

    logic at_max;

    assign at_max = &cnt;

    // NOTE: clear takes priority, but an increment in the same cycle is still counted.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= inc ? CNT_W'(1) : '0;
        end else if (inc && !(SAT && at_max)) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/even_parity_check_stream.sv
// Checks {data, even parity} words on a valid/ready stream, forwards them through one
// register stage tagged with an error bit, and keeps frame/error statistics.
module even_parity_check_stream
    import even_parity_pkg::*;
#(
    parameter int DATA_W = even_parity_pkg::DATA_W,
    parameter int CNT_W  = even_parity_pkg::CNT_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_parity,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_err,
    input  logic              clr_stats,
    output logic              err_sticky,
    output logic [CNT_W-1:0]  frame_cnt,
    output logic [CNT_W-1:0]  err_cnt
);

    logic accept;
    logic err;

    // NOTE: in_ready depends only on register state and out_ready, never on in_valid.
    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready;
    assign err      = even_parity(PARITY_MAX_W'(in_data)) ^ in_parity;

    // One-entry output register: out_valid is the EMPTY/FULL state.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_err   <= 1'b0;
        end else if (accept) begin
            out_valid <= 1'b1;
            out_data  <= in_data;
            out_err   <= err;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            err_sticky <= 1'b0;
        end else if (clr_stats) begin
            err_sticky <= accept && err;
        end else if (accept && err) begin
            err_sticky <= 1'b1;
        end
    end

    parity_stat_counter #(
        .CNT_W (CNT_W),
        .SAT   (1'b0)
    ) u_frame_cnt (
        .clk (clk),
        .rst (rst),
        .clr (clr_stats),
        .inc (accept),
        .cnt (frame_cnt)
    );

    parity_stat_counter #(
        .CNT_W (CNT_W),
        .SAT   (1'b1)
    ) u_err_cnt (
        .clk (clk),
        .rst (rst),
        .clr (clr_stats),
        .inc (accept && err),
        .cnt (err_cnt)
    );

endmodule

// File: tb/tb_even_parity_check_stream.sv
// Directed bench for even_parity_check_stream with 4-bit counters to reach wrap/saturation.
module tb_even_parity_check_stream;

    localparam int DATA_W = 8;
    localparam int CNT_W  = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              in_parity;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic              out_err;
    logic              clr_stats;
    logic              err_sticky;
    logic [CNT_W-1:0]  frame_cnt;
    logic [CNT_W-1:0]  err_cnt;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    even_parity_check_stream #(
        .DATA_W (DATA_W),
        .CNT_W  (CNT_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .in_parity  (in_parity),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_err    (out_err),
        .clr_stats  (clr_stats),
        .err_sticky (err_sticky),
        .frame_cnt  (frame_cnt),
        .err_cnt    (err_cnt)
    );

    task automatic check(input string tag, input logic [15:0] observed, input logic [15:0] expected);
        vectors++;
        assert (observed === expected)
        else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    // Advance one clock and settle just after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [7:0] d, input logic p);
        in_valid  = v;
        in_data   = d;
        in_parity = p;
    endtask

    task automatic check_word(input string tag, input logic [7:0] d, input logic e);
        check({tag, ".out_valid"}, 16'(out_valid), 16'd1);
        check({tag, ".out_data"},  16'(out_data),  16'(d));
        check({tag, ".out_err"},   16'(out_err),   16'(e));
    endtask

    task automatic check_stats(input string tag, input logic [3:0] f, input logic [3:0] e, input logic s);
        check({tag, ".frame_cnt"},  16'(frame_cnt),  16'(f));
        check({tag, ".err_cnt"},    16'(err_cnt),    16'(e));
        check({tag, ".err_sticky"}, 16'(err_sticky), 16'(s));
    endtask

    initial begin
        rst       = 1'b1;
        clr_stats = 1'b0;
        out_ready = 1'b1;
        drive(1'b0, 8'h00, 1'b0);
        step();
        step();
        check("rst.out_valid", 16'(out_valid), 16'd0);
        check("rst.out_data",  16'(out_data),  16'd0);
        check("rst.out_err",   16'(out_err),   16'd0);
        check_stats("rst", 4'd0, 4'd0, 1'b0);
        rst = 1'b0;
        check("rst.in_ready", 16'(in_ready), 16'd1);

        // Good stream at full throughput
        drive(1'b1, 8'hA5, 1'b0); step(); check_word("good0", 8'hA5, 1'b0);
        drive(1'b1, 8'h01, 1'b1); step(); check_word("good1", 8'h01, 1'b0);
        drive(1'b1, 8'hFF, 1'b0); step(); check_word("good2", 8'hFF, 1'b0);
        drive(1'b0, 8'h00, 1'b0); step();
        check("good.drain", 16'(out_valid), 16'd0);
        check_stats("good", 4'd3, 4'd0, 1'b0);

        // Bad word then good word: sticky holds
        drive(1'b1, 8'h03, 1'b1); step(); check_word("bad", 8'h03, 1'b1);
        check_stats("bad", 4'd4, 4'd1, 1'b1);
        drive(1'b1, 8'h00, 1'b0); step(); check_word("after_bad", 8'h00, 1'b0);
        check_stats("after_bad", 4'd5, 4'd1, 1'b1);
        drive(1'b0, 8'h00, 1'b0); step();

        // Backpressure: first word held, second word waits upstream
        out_ready = 1'b0;
        drive(1'b1, 8'h5A, 1'b0); step(); check_word("bp.first", 8'h5A, 1'b0);
        drive(1'b1, 8'h07, 1'b1);
        check("bp.in_ready", 16'(in_ready), 16'd0);
        for (int i = 0; i < 5; i++) begin
            step();
            check_word("bp.hold", 8'h5A, 1'b0);
            check("bp.hold.in_ready", 16'(in_ready), 16'd0);
        end
        check("bp.frame_cnt", 16'(frame_cnt), 16'd6);
        out_ready = 1'b1;
        #1;
        check("bp.release.in_ready", 16'(in_ready), 16'd1);
        step(); check_word("bp.second", 8'h07, 1'b0);
        drive(1'b0, 8'h00, 1'b0); step();
        check("bp.drain", 16'(out_valid), 16'd0);
        check("bp.frames", 16'(frame_cnt), 16'd7);

        // Counter limits
        clr_stats = 1'b1; step(); clr_stats = 1'b0;
        check_stats("clr", 4'd0, 4'd0, 1'b0);
        drive(1'b1, 8'h00, 1'b0);
        for (int i = 0; i < 16; i++) step();
        check_stats("wrap", 4'd0, 4'd0, 1'b0);
        drive(1'b1, 8'h01, 1'b0);
        for (int i = 0; i < 15; i++) step();
        check_stats("sat15", 4'd15, 4'd15, 1'b1);
        for (int i = 0; i < 5; i++) step();
        check_stats("sat20", 4'd4, 4'd15, 1'b1);
        check_word("sat.last", 8'h01, 1'b1);

        // Clear coincident with accepted words
        drive(1'b1, 8'h80, 1'b0); clr_stats = 1'b1; step();
        check_stats("clr_bad", 4'd1, 4'd1, 1'b1);
        drive(1'b1, 8'h81, 1'b0); step();
        check_stats("clr_good", 4'd1, 4'd0, 1'b0);
        check_word("clr_good", 8'h81, 1'b0);

        // Clear alone leaves a held output word untouched
        out_ready = 1'b0;
        drive(1'b0, 8'h00, 1'b0); step();
        check_word("clr_hold", 8'h81, 1'b0);
        check_stats("clr_hold", 4'd0, 4'd0, 1'b0);
        clr_stats = 1'b0;

        // Build up stats, then reset while a word is pending
        drive(1'b1, 8'h01, 1'b0); out_ready = 1'b1; step(); step();
        out_ready = 1'b0; step();
        check_word("pre_rst", 8'h01, 1'b1);
        check_stats("pre_rst", 4'd2, 4'd2, 1'b1);
        rst = 1'b1; step(); rst = 1'b0;
        drive(1'b0, 8'h00, 1'b0);
        check("mid_rst.out_valid", 16'(out_valid), 16'd0);
        check("mid_rst.out_data",  16'(out_data),  16'd0);
        check("mid_rst.in_ready",  16'(in_ready),  16'd1);
        check_stats("mid_rst", 4'd0, 4'd0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
